int_controller: RTL

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/int_controller.sv
// Fixed-priority interrupt controller: edge-detected pending register, mask, IDLE/REQ/SERV handshake.
// Optional INTC_SYNC_EN macro adds a 2-flop synchronizer on every irq_in bit ahead of edge detection.
module int_controller #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_in,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             ir1,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERV
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_SRC-1:0]  r_prev;
    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_mask;
    logic              r_ir1;
    logic [ID_W-1:0]   r_int_id;
    logic [N_SRC-1:0]  w_sampled;
    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_eligible;
    logic [N_SRC-1:0]  w_clr;
    logic              w_ir1_nxt;
    logic [ID_W-1:0]   w_id_nxt;

    // Lowest set index wins; returns 0 for an all-zero vector (caller gates on |v).
    function automatic logic [ID_W-1:0] f_first(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sampled = r_sync2;
`else
    assign w_sampled = irq_in;
`endif

    // The previous-sample flop clears to 0, so a line held high through reset release is one event.
    assign w_rise     = w_sampled & ~r_prev;
    assign w_eligible = r_pending & r_mask;

    always_comb begin
        w_clr = '0;
        if (r_state == ST_REQ && int_ack) begin
            w_clr[r_int_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_prev    <= w_sampled;
            // A new edge in the ack cycle must survive the clear of the serviced bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_ir1    <= 1'b0;
            r_int_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ir1    <= w_ir1_nxt;
            r_int_id <= w_id_nxt;
        end
    end

    // Arbitration happens only on leaving IDLE; REQ and SERV hold the latched index.
    always_comb begin
        w_state_nxt = r_state;
        w_ir1_nxt   = r_ir1;
        w_id_nxt    = r_int_id;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = ST_REQ;
                    w_ir1_nxt   = 1'b1;
                    w_id_nxt    = f_first(w_eligible);
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = ST_SERV;
                    w_ir1_nxt   = 1'b0;
                end
            end
            ST_SERV: begin
                if (int_eoi) begin
                    w_state_nxt = ST_IDLE;
                    w_id_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ir1_nxt   = 1'b0;
                w_id_nxt    = '0;
            end
        endcase
    end

    assign ir1     = r_ir1;
    assign int_id  = r_int_id;
    assign pending = r_pending;

endmodule
